vdp_cpu_port: RTL and testbench
===============================

// Module: vdp_cpu_port
// PURPOSE
//  CPU-side host interface of the VDP: decodes 8-bit data/control port accesses into VRAM
//  writes, read-ahead VRAM reads and VDP register writes. Sits upstream of the VDP display
//  core; the VDP muxes its RAM between display fetch and this block, granting free cycles.
// PARAMETERS
//  RamBits   16  VRAM address width; legal range 14..16; addresses wrap mod 2**RamBits
//  RegCount  8   number of VDP registers; regIndex width = 3
// PORTS
//  clk          in   1        system clock; all state changes on posedge
//  reset        in   1        asynchronous, active-low reset (0 = in reset)
//  cpuSel       in   1        one-cycle access strobe
//  cpuWr        in   1        1 = write, 0 = read (sampled with cpuSel)
//  cpuMode      in   1        0 = data port, 1 = control port
//  cpuDataIn    in   8        CPU write data
//  cpuDataOut   out  8        CPU read data, registered, valid cycle after read strobe
//  cpuWait      out  1        1 while a VRAM transfer is pending
//  vramReq      out  1        request a VRAM slot
//  vramWe       out  1        1 = pending request is a write
//  vramAddress  out  RamBits  VRAM address of pending request
//  vramDataOut  out  8        VRAM write data
//  vramGrant    in   1        VDP grants slot this cycle; transfer = vramReq && vramGrant
//  vramDataIn   in   8        VRAM read data, valid one cycle after granted read
//  regWrite     out  1        one-cycle register write pulse
//  regIndex     out  3        register number
//  regData      out  8        register value
// BEHAVIOUR
//  Reset (reset=0, immediate): state IDLE; all outputs 0; addr=0, page=0, latch toggle=0,
//   readBuf=0, overrun=0. Reset mid-transfer drops it; no vramWe pulse follows.
//  Control write, toggle=0: byte1<=cpuDataIn, toggle<=1.
//  Control write, toggle=1: toggle<=0; cmd=cpuDataIn[7:6]:
//   00 set read addr: addr<={page,cpuDataIn[5:0],byte1}[RamBits-1:0]; enter RD_WAIT (prefetch)
//   01 set write addr: same address load, stay IDLE
//   10 reg write: next cycle regWrite=1, regIndex=cpuDataIn[2:0], regData=byte1
//   11 page: page<=byte1[1:0] (bits above RamBits ignored)
//  Control read: cpuDataOut={pending,overrun,6'b0}; clears overrun and toggle.
//  Data write: vramDataOut<=cpuDataIn, vramWe<=1, enter WR_WAIT; clears toggle.
//  Data read: cpuDataOut<=readBuf; enter RD_WAIT (prefetch at addr); clears toggle.
//  FSM: IDLE; WR_WAIT --grant--> IDLE, addr+1; RD_WAIT --grant--> RD_DATA, addr+1;
//   RD_DATA: readBuf<=vramDataIn --> IDLE. Each state holds until its grant arrives.
//  vramReq=1 and cpuWait=1 exactly in WR_WAIT/RD_WAIT/RD_DATA; vramAddress=addr.
//  Min latency: strobe at edge N -> vramReq from N+1 -> grant in N+1 -> IDLE at N+2.
//  Any cpuSel while cpuWait=1, except a control read, is ignored and sets overrun=1;
//   a control read is always served.
//  Address increment wraps 2**RamBits-1 -> 0. regWrite never coincides with a VRAM request.
// STRUCTURE
//  Shared include VdpDefs.v: `defines for command codes (00/01/10/11), status bit positions
//   (7 pending, 6 overrun), FSM state encodings, default RamBits.
//  Single module; no sub-module (FSM + latch + buffers are small).
// TESTING
//  Ctrl 0x34,0x52 then data 0xAB, grant held 1 -> one vramWe cycle, addr 0x1234, data 0xAB; addr->0x1235
//  Ctrl 0x00,0x00 (read setup) then data read, VRAM[0]=0x11, VRAM[1]=0x22 -> first read returns 0x11,
//   second returns 0x22, addr=2
//  Ctrl 0x07,0x83 -> regWrite pulse 1 cycle, regIndex=3, regData=0x07; no vramReq
//  Grant held 0 for 20 cycles after data write, data write during wait -> cpuWait=1 throughout,
//   second write dropped; status read = 0xC0, next status read = 0x80 (or 0x00 once done)
//  Page 0x03 via cmd 11, write addr 0xFF,0x7F, two writes (RamBits=16) -> addresses 0xFFFF, 0x0000
//  Reset low during WR_WAIT -> vramReq/vramWe/cpuWait drop at once; release -> IDLE, addr=0, toggle=0

Source files
------------

// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU port: command codes, status bit layout,
// FSM states and default geometry.
package vdp_cpu_port_pkg;

   localparam int DefaultRamBits   = 16;
   localparam int DefaultRegCount  = 8;
   localparam int StatusPendingBit = 7;
   localparam int StatusOverrunBit = 6;

   typedef enum logic [1:0] {
      CmdSetRead  = 2'b00,
      CmdSetWrite = 2'b01,
      CmdRegWrite = 2'b10,
      CmdPage     = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StWrWait = 2'b01,
      StRdWait = 2'b10,
      StRdData = 2'b11
   } state_e;

   function automatic logic [7:0] statusByte(input logic pending, input logic overrun);
      logic [7:0] s;
      s = '0;
      s[StatusPendingBit] = pending;
      s[StatusOverrunBit] = overrun;
      return s;
   endfunction

endpackage

// File: rtl/vdp_cpu_port.sv
// CPU host interface of the VDP: turns data/control port strobes into VRAM
// writes, read-ahead VRAM reads and VDP register writes.
module vdp_cpu_port
   import vdp_cpu_port_pkg::*;
#(
   parameter int RamBits  = DefaultRamBits,
   parameter int RegCount = DefaultRegCount
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cpuSel,
   input  logic                        cpuWr,
   input  logic                        cpuMode,
   input  logic [7:0]                  cpuDataIn,
   output logic [7:0]                  cpuDataOut,
   output logic                        cpuWait,
   output logic                        vramReq,
   output logic                        vramWe,
   output logic [RamBits-1:0]          vramAddress,
   output logic [7:0]                  vramDataOut,
   input  logic                        vramGrant,
   input  logic [7:0]                  vramDataIn,
   output logic                        regWrite,
   output logic [$clog2(RegCount)-1:0] regIndex,
   output logic [7:0]                  regData
);

   state_e                      state_q;
   logic [RamBits-1:0]          addr_q;
   logic [1:0]                  page_q;
   logic [7:0]                  byte1_q;
   logic                        toggle_q;
   logic [7:0]                  readBuf_q;
   logic                        overrun_q;
   logic [7:0]                  cpuDataOut_q;
   logic [7:0]                  vramDataOut_q;
   logic                        regWrite_q;
   logic [$clog2(RegCount)-1:0] regIndex_q;
   logic [7:0]                  regData_q;

   logic                        busy;
   logic                        ctrlRead;
   logic [15:0]                 fullAddr;
   logic [RamBits-1:0]          addrInc;

   assign busy     = (state_q != StIdle);
   assign ctrlRead = cpuSel && !cpuWr && cpuMode;
   assign fullAddr = {page_q, cpuDataIn[5:0], byte1_q};
   assign addrInc  = addr_q + RamBits'(1);

   // Host strobes are only accepted while idle, and the FSM only advances while
   // busy, so the two halves never assign the same register in one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         page_q        <= '0;
         byte1_q       <= '0;
         toggle_q      <= 1'b0;
         readBuf_q     <= '0;
         overrun_q     <= 1'b0;
         cpuDataOut_q  <= '0;
         vramDataOut_q <= '0;
         regWrite_q    <= 1'b0;
         regIndex_q    <= '0;
         regData_q     <= '0;
      end else begin
         regWrite_q <= 1'b0;
         if (ctrlRead) begin
            cpuDataOut_q <= statusByte(busy, overrun_q);
            overrun_q    <= 1'b0;
            toggle_q     <= 1'b0;
         end else if (cpuSel && busy) begin
            overrun_q <= 1'b1;
         end else if (cpuSel) begin
            if (cpuMode) begin
               if (!toggle_q) begin
                  byte1_q  <= cpuDataIn;
                  toggle_q <= 1'b1;
               end else begin
                  toggle_q <= 1'b0;
                  unique case (cmd_e'(cpuDataIn[7:6]))
                     CmdSetRead: begin
                        addr_q  <= fullAddr[RamBits-1:0];
                        state_q <= StRdWait;
                     end
                     CmdSetWrite: addr_q <= fullAddr[RamBits-1:0];
                     CmdRegWrite: begin
                        regWrite_q <= 1'b1;
                        regIndex_q <= cpuDataIn[$clog2(RegCount)-1:0];
                        regData_q  <= byte1_q;
                     end
                     CmdPage: page_q <= byte1_q[1:0];
                  endcase
               end
            end else if (cpuWr) begin
               vramDataOut_q <= cpuDataIn;
               state_q       <= StWrWait;
               toggle_q      <= 1'b0;
            end else begin
               cpuDataOut_q <= readBuf_q;
               state_q      <= StRdWait;
               toggle_q     <= 1'b0;
            end
         end

         unique case (state_q)
            StIdle: ;
            StWrWait: if (vramGrant) begin
               state_q <= StIdle;
               addr_q  <= addrInc;
            end
            StRdWait: if (vramGrant) begin
               state_q <= StRdData;
               addr_q  <= addrInc;
            end
            StRdData: begin
               readBuf_q <= vramDataIn;
               state_q   <= StIdle;
            end
         endcase
      end
   end

   assign cpuDataOut  = cpuDataOut_q;
   assign cpuWait     = busy;
   assign vramReq     = busy;
   assign vramWe      = (state_q == StWrWait);
   assign vramAddress = addr_q;
   assign vramDataOut = vramDataOut_q;
   assign regWrite    = regWrite_q;
   assign regIndex    = regIndex_q;
   assign regData     = regData_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM model answering granted requests.
module tb_vdp_cpu_port;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpuSel = 1'b0;
   logic        cpuWr = 1'b0;
   logic        cpuMode = 1'b0;
   logic [7:0]  cpuDataIn = 8'h00;
   logic [7:0]  cpuDataOut;
   logic        cpuWait;
   logic        vramReq;
   logic        vramWe;
   logic [15:0] vramAddress;
   logic [7:0]  vramDataOut;
   logic        vramGrant;
   logic [7:0]  vramDataIn = 8'h00;
   logic        regWrite;
   logic [2:0]  regIndex;
   logic [7:0]  regData;

   logic        grantEn = 1'b1;
   logic [7:0]  mem [0:65535];
   int          testsRun = 0;
   int          testsFailed = 0;

   assign vramGrant = grantEn;

   vdp_cpu_port dut (
      .clk(clk), .reset(reset), .cpuSel(cpuSel), .cpuWr(cpuWr), .cpuMode(cpuMode),
      .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuWait(cpuWait),
      .vramReq(vramReq), .vramWe(vramWe), .vramAddress(vramAddress),
      .vramDataOut(vramDataOut), .vramGrant(vramGrant), .vramDataIn(vramDataIn),
      .regWrite(regWrite), .regIndex(regIndex), .regData(regData)
   );

   always #5 clk = ~clk;

   // VRAM model: writes land on a granted write, read data appears one cycle after a granted read.
   always @(posedge clk) begin
      if (vramReq && vramGrant) begin
         if (vramWe) mem[vramAddress] <= vramDataOut;
         else        vramDataIn <= mem[vramAddress];
      end
   end

   // One-cycle strobe; returns on the falling edge after the DUT has consumed it.
   task automatic strobe(input logic mode, input logic wr, input logic [7:0] data);
      @(negedge clk);
      cpuSel = 1'b1; cpuMode = mode; cpuWr = wr; cpuDataIn = data;
      @(negedge clk);
      cpuSel = 1'b0; cpuWr = 1'b0; cpuMode = 1'b0; cpuDataIn = 8'h00;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #12;
      testsRun += 5;
      if (vramReq !== 1'b0)        begin testsFailed++; $display("[TB] FAIL reset_vramReq got %b want 0", vramReq); end
      if (cpuWait !== 1'b0)        begin testsFailed++; $display("[TB] FAIL reset_cpuWait got %b want 0", cpuWait); end
      if (cpuDataOut !== 8'h00)    begin testsFailed++; $display("[TB] FAIL reset_cpuDataOut got %h want 00", cpuDataOut); end
      if (vramAddress !== 16'h0)   begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 0000", vramAddress); end
      if (regWrite !== 1'b0)       begin testsFailed++; $display("[TB] FAIL reset_regWrite got %b want 0", regWrite); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write;
      grantEn = 1'b1;
      strobe(1'b1, 1'b1, 8'h34);
      strobe(1'b1, 1'b1, 8'h52);
      testsRun += 2;
      if (vramAddress !== 16'h1234) begin testsFailed++; $display("[TB] FAIL wr_setaddr got %h want 1234", vramAddress); end
      if (vramReq !== 1'b0)         begin testsFailed++; $display("[TB] FAIL wr_setaddr_noreq got %b want 0", vramReq); end
      strobe(1'b0, 1'b1, 8'hAB);
      testsRun += 3;
      if ({vramReq, vramWe} !== 2'b11) begin testsFailed++; $display("[TB] FAIL wr_req got %b want 11", {vramReq, vramWe}); end
      if (vramAddress !== 16'h1234)    begin testsFailed++; $display("[TB] FAIL wr_addr got %h want 1234", vramAddress); end
      if (vramDataOut !== 8'hAB)       begin testsFailed++; $display("[TB] FAIL wr_data got %h want ab", vramDataOut); end
      @(negedge clk);
      testsRun += 3;
      if (vramWe !== 1'b0)          begin testsFailed++; $display("[TB] FAIL wr_we_one_cycle got %b want 0", vramWe); end
      if (vramAddress !== 16'h1235) begin testsFailed++; $display("[TB] FAIL wr_addr_inc got %h want 1235", vramAddress); end
      if (mem[16'h1234] !== 8'hAB)  begin testsFailed++; $display("[TB] FAIL wr_mem got %h want ab", mem[16'h1234]); end
   endtask

   task automatic test_read;
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      strobe(1'b1, 1'b1, 8'h00);
      strobe(1'b1, 1'b1, 8'h00);
      testsRun += 2;
      if ({vramReq, vramWe} !== 2'b10) begin testsFailed++; $display("[TB] FAIL rd_prefetch_req got %b want 10", {vramReq, vramWe}); end
      if (vramAddress !== 16'h0000)    begin testsFailed++; $display("[TB] FAIL rd_prefetch_addr got %h want 0000", vramAddress); end
      repeat (2) @(negedge clk);
      testsRun += 2;
      if (cpuWait !== 1'b0)         begin testsFailed++; $display("[TB] FAIL rd_prefetch_done got %b want 0", cpuWait); end
      if (vramAddress !== 16'h0001) begin testsFailed++; $display("[TB] FAIL rd_addr1 got %h want 0001", vramAddress); end
      strobe(1'b0, 1'b0, 8'h00);
      testsRun++;
      if (cpuDataOut !== 8'h11) begin testsFailed++; $display("[TB] FAIL rd_first got %h want 11", cpuDataOut); end
      repeat (2) @(negedge clk);
      testsRun++;
      if (vramAddress !== 16'h0002) begin testsFailed++; $display("[TB] FAIL rd_addr2 got %h want 0002", vramAddress); end
      strobe(1'b0, 1'b0, 8'h00);
      testsRun++;
      if (cpuDataOut !== 8'h22) begin testsFailed++; $display("[TB] FAIL rd_second got %h want 22", cpuDataOut); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reg;
      strobe(1'b1, 1'b1, 8'h07);
      strobe(1'b1, 1'b1, 8'h83);
      testsRun += 4;
      if (regWrite !== 1'b1)  begin testsFailed++; $display("[TB] FAIL reg_pulse got %b want 1", regWrite); end
      if (regIndex !== 3'd3)  begin testsFailed++; $display("[TB] FAIL reg_index got %0d want 3", regIndex); end
      if (regData !== 8'h07)  begin testsFailed++; $display("[TB] FAIL reg_data got %h want 07", regData); end
      if (vramReq !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reg_noreq got %b want 0", vramReq); end
      @(negedge clk);
      testsRun++;
      if (regWrite !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reg_pulse_end got %b want 0", regWrite); end
   endtask

   task automatic test_overrun;
      int waitDrops;
      strobe(1'b1, 1'b1, 8'h00);
      strobe(1'b1, 1'b1, 8'h40);
      @(negedge clk);
      grantEn = 1'b0;
      strobe(1'b0, 1'b1, 8'h55);
      strobe(1'b0, 1'b1, 8'h66);
      waitDrops = 0;
      for (int i = 0; i < 20; i++) begin
         if (cpuWait !== 1'b1) waitDrops++;
         @(negedge clk);
      end
      testsRun += 2;
      if (waitDrops != 0)        begin testsFailed++; $display("[TB] FAIL ovr_wait_held got %0d drops want 0", waitDrops); end
      if (vramDataOut !== 8'h55) begin testsFailed++; $display("[TB] FAIL ovr_data_kept got %h want 55", vramDataOut); end
      strobe(1'b1, 1'b0, 8'h00);
      testsRun++;
      if (cpuDataOut !== 8'hC0) begin testsFailed++; $display("[TB] FAIL ovr_status1 got %h want c0", cpuDataOut); end
      strobe(1'b1, 1'b0, 8'h00);
      testsRun++;
      if (cpuDataOut !== 8'h80) begin testsFailed++; $display("[TB] FAIL ovr_status2 got %h want 80", cpuDataOut); end
      grantEn = 1'b1;
      @(negedge clk);
      testsRun += 3;
      if (cpuWait !== 1'b0)         begin testsFailed++; $display("[TB] FAIL ovr_done got %b want 0", cpuWait); end
      if (vramAddress !== 16'h0001) begin testsFailed++; $display("[TB] FAIL ovr_addr got %h want 0001", vramAddress); end
      if (mem[0] !== 8'h55)         begin testsFailed++; $display("[TB] FAIL ovr_mem got %h want 55", mem[0]); end
      strobe(1'b1, 1'b0, 8'h00);
      testsRun++;
      if (cpuDataOut !== 8'h00) begin testsFailed++; $display("[TB] FAIL ovr_status3 got %h want 00", cpuDataOut); end
   endtask

   task automatic test_page_wrap;
      strobe(1'b1, 1'b1, 8'h03);
      strobe(1'b1, 1'b1, 8'hC0);
      strobe(1'b1, 1'b1, 8'hFF);
      strobe(1'b1, 1'b1, 8'h7F);
      testsRun++;
      if (vramAddress !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL page_addr got %h want ffff", vramAddress); end
      strobe(1'b0, 1'b1, 8'hA1);
      @(negedge clk);
      testsRun++;
      if (vramAddress !== 16'h0000) begin testsFailed++; $display("[TB] FAIL wrap_addr got %h want 0000", vramAddress); end
      strobe(1'b0, 1'b1, 8'hA2);
      testsRun++;
      if (vramAddress !== 16'h0000) begin testsFailed++; $display("[TB] FAIL wrap_wr2_addr got %h want 0000", vramAddress); end
      @(negedge clk);
      testsRun += 2;
      if (mem[16'hFFFF] !== 8'hA1) begin testsFailed++; $display("[TB] FAIL wrap_mem_ffff got %h want a1", mem[16'hFFFF]); end
      if (mem[0] !== 8'hA2)        begin testsFailed++; $display("[TB] FAIL wrap_mem_0000 got %h want a2", mem[0]); end
   endtask

   task automatic test_reset_midwrite;
      grantEn = 1'b0;
      strobe(1'b0, 1'b1, 8'h99);
      testsRun++;
      if (vramWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_pre_we got %b want 1", vramWe); end
      #2 reset = 1'b0;
      #1;
      testsRun += 4;
      if (vramReq !== 1'b0)       begin testsFailed++; $display("[TB] FAIL rst_req got %b want 0", vramReq); end
      if (vramWe !== 1'b0)        begin testsFailed++; $display("[TB] FAIL rst_we got %b want 0", vramWe); end
      if (cpuWait !== 1'b0)       begin testsFailed++; $display("[TB] FAIL rst_wait got %b want 0", cpuWait); end
      if (vramAddress !== 16'h0)  begin testsFailed++; $display("[TB] FAIL rst_addr got %h want 0000", vramAddress); end
      @(negedge clk);
      reset = 1'b1;
      grantEn = 1'b1;
      repeat (2) @(negedge clk);
      testsRun += 2;
      if (vramWe !== 1'b0)  begin testsFailed++; $display("[TB] FAIL rst_no_we_after got %b want 0", vramWe); end
      if (mem[1] !== 8'h22) begin testsFailed++; $display("[TB] FAIL rst_mem_untouched got %h want 22", mem[1]); end
      // Leave the address latch half-loaded, then check reset clears the toggle.
      strobe(1'b1, 1'b1, 8'h12);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      strobe(1'b1, 1'b1, 8'h34);
      strobe(1'b1, 1'b1, 8'h56);
      testsRun += 2;
      if (vramAddress !== 16'h1634) begin testsFailed++; $display("[TB] FAIL rst_toggle_addr got %h want 1634", vramAddress); end
      if (vramReq !== 1'b0)         begin testsFailed++; $display("[TB] FAIL rst_toggle_noreq got %b want 0", vramReq); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_reg();
      test_overrun();
      test_page_wrap();
      test_reset_midwrite();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
